// File: rtl/sram_stream_reader_if.sv
// rtl/sram_stream_reader_if.sv - SRAM port A and byte stream signal bundle for sram_stream_reader
interface sram_stream_reader_if #(
  parameter int SRAM_ADDR_WD = 8,
  parameter int SRAM_DATA_WD = 32
);
  logic                    sram_csb_a;
  logic [SRAM_ADDR_WD-1:0] sram_addr_a;
  logic [SRAM_DATA_WD-1:0] sram_dout_a;
  logic [7:0]              m_byte_o;
  logic                    m_valid_o;
  logic                    m_ready_i;

  // reader side: drives the SRAM request and the byte stream
  modport master (
    output sram_csb_a, sram_addr_a, m_byte_o, m_valid_o,
    input  sram_dout_a, m_ready_i
  );

  // environment side: SRAM macro port A plus the UART TX consumer
  modport slave (
    input  sram_csb_a, sram_addr_a, m_byte_o, m_valid_o,
    output sram_dout_a, m_ready_i
  );
endinterface

// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - reads a block of SRAM port A words and streams them LSB-first as bytes; optional prefetch via SRAM_STREAM_PREFETCH_EN
module sram_stream_reader #(
  parameter int SRAM_ADDR_WD = 8,
  parameter int SRAM_DATA_WD = 32,
  parameter int RD_LAT       = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [SRAM_ADDR_WD-1:0] base_addr_i,
  input  logic [SRAM_ADDR_WD:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  sram_stream_reader_if.master  bus
);
  localparam int         CW       = SRAM_ADDR_WD + 1;
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SEND, S_DONE} state_t;

  state_t                  state_q, state_n;
  logic [SRAM_ADDR_WD-1:0] base_q, base_n, addr_q, addr_n;
  logic [CW-1:0]           len_q, len_n, word_idx_q, word_idx_n, rd_cnt_q, rd_cnt_n;
  logic [1:0]              idx_q, idx_n, lat_q, lat_n;
  logic [SRAM_DATA_WD-1:0] word_q, word_n;
  logic                    csb_q, rd_pend_q, rd_pend_n;
  logic                    issue, fire, cap, more;
`ifdef SRAM_STREAM_PREFETCH_EN
  logic [SRAM_DATA_WD-1:0] hold_q, hold_n;
  logic                    hold_v_q, hold_v_n, cap_used;
`endif

  assign busy_o        = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_SEND);
  assign done_o        = (state_q == S_DONE);
  assign bus.sram_csb_a  = csb_q;
  assign bus.sram_addr_a = addr_q;
  assign bus.m_valid_o   = (state_q == S_SEND);
  assign bus.m_byte_o    = word_q[{idx_q, 3'b000} +: 8];

  // next-state, read issue and outstanding-read tracking
  always_comb begin
    state_n    = state_q;
    base_n     = base_q;
    len_n      = len_q;
    word_idx_n = word_idx_q;
    rd_cnt_n   = rd_cnt_q;
    idx_n      = idx_q;
    word_n     = word_q;
    addr_n     = addr_q;
    issue      = 1'b0;
    fire       = (state_q == S_SEND) && bus.m_ready_i;
    cap        = rd_pend_q && (lat_q == LAT_LAST);
    more       = (word_idx_q + 1'b1) < len_q;
`ifdef SRAM_STREAM_PREFETCH_EN
    hold_n     = hold_q;
    hold_v_n   = hold_v_q;
    cap_used   = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (start_i) begin
          if (len_i == '0) begin
            state_n = S_DONE;
          end else begin
            base_n     = base_addr_i;
            len_n      = len_i;
            word_idx_n = '0;
            rd_cnt_n   = '0;
            idx_n      = 2'd0;
            state_n    = S_READ;
          end
        end
      end
      S_READ: state_n = S_WAIT;
      S_WAIT: begin
        if (cap) begin
          word_n  = bus.sram_dout_a;
          idx_n   = 2'd0;
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (fire) begin
          idx_n = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (more) begin
              word_idx_n = word_idx_q + 1'b1;
`ifdef SRAM_STREAM_PREFETCH_EN
              if (hold_v_q) begin
                word_n   = hold_q;
                hold_v_n = 1'b0;
              end else if (cap) begin
                word_n   = bus.sram_dout_a;
                cap_used = 1'b1;
              end else begin
                state_n = S_WAIT;
              end
`else
              state_n = S_READ;
`endif
            end else begin
              state_n = S_DONE;
            end
          end
        end
`ifdef SRAM_STREAM_PREFETCH_EN
        if (cap && !cap_used) begin
          hold_n   = bus.sram_dout_a;
          hold_v_n = 1'b1;
        end
`endif
      end
      default: state_n = S_IDLE;
    endcase

    // abort wins over everything else and drops any in-flight data
    if (busy_o && abort_i) begin
      state_n = S_IDLE;
      idx_n   = 2'd0;
`ifdef SRAM_STREAM_PREFETCH_EN
      hold_v_n = 1'b0;
`endif
    end

    if (state_n == S_READ) issue = 1'b1;
`ifdef SRAM_STREAM_PREFETCH_EN
    // fetch the next word while the current one drains, one read in flight at most
    if ((state_n == S_SEND) && (idx_n != 2'd0) && !rd_pend_q && csb_q &&
        !hold_v_n && (rd_cnt_q < len_q))
      issue = 1'b1;
`endif
    if (issue) begin
      addr_n   = base_n + rd_cnt_n[SRAM_ADDR_WD-1:0];
      rd_cnt_n = rd_cnt_n + 1'b1;
    end

    // a read becomes outstanding on the edge the SRAM samples csb low
    rd_pend_n = rd_pend_q;
    lat_n     = lat_q;
    if (!csb_q) begin
      rd_pend_n = 1'b1;
      lat_n     = 2'd0;
    end else if (cap) begin
      rd_pend_n = 1'b0;
    end else if (rd_pend_q) begin
      lat_n = lat_q + 2'd1;
    end
    if (busy_o && abort_i) rd_pend_n = 1'b0;
  end

  // state and datapath registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      rd_cnt_q   <= '0;
      idx_q      <= 2'd0;
      lat_q      <= 2'd0;
      word_q     <= '0;
      addr_q     <= '0;
      csb_q      <= 1'b1;
      rd_pend_q  <= 1'b0;
`ifdef SRAM_STREAM_PREFETCH_EN
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      base_q     <= base_n;
      len_q      <= len_n;
      word_idx_q <= word_idx_n;
      rd_cnt_q   <= rd_cnt_n;
      idx_q      <= idx_n;
      lat_q      <= lat_n;
      word_q     <= word_n;
      addr_q     <= addr_n;
      csb_q      <= !issue;
      rd_pend_q  <= rd_pend_n;
`ifdef SRAM_STREAM_PREFETCH_EN
      hold_q     <= hold_n;
      hold_v_q   <= hold_v_n;
`endif
    end
  end
endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - scoreboard bench for sram_stream_reader
`timescale 1ns/1ps
module tb_sram_stream_reader;
  localparam int AW     = 8;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          busy, done;

  sram_stream_reader_if #(.SRAM_ADDR_WD(AW), .SRAM_DATA_WD(32)) bus ();

  sram_stream_reader #(.SRAM_ADDR_WD(AW), .SRAM_DATA_WD(32), .RD_LAT(RD_LAT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .abort_i(abort),
    .base_addr_i(base), .len_i(len), .busy_o(busy), .done_o(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0]   mem [0:255];
  logic [7:0]    exp_q[$];
  logic [AW-1:0] rd_log[$];
  logic          vlog[$];
  int            tests_run = 0, tests_failed = 0;
  int            done_cnt = 0, csb_low_cnt = 0, done_qsize = -1;
  bit            busy_seen = 0, hold_chk = 0;
  logic          prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0]    prev_b = 8'h00, mon_exp;

  // SRAM port A model with a one-cycle registered read
  always @(posedge clk) begin
    if (!bus.sram_csb_a) begin
      bus.sram_dout_a <= mem[bus.sram_addr_a];
      rd_log.push_back(bus.sram_addr_a);
    end
  end

  // stream monitor: scoreboard pop, hold-stability and event counters
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin done_cnt++; done_qsize = exp_q.size(); end
      if (!bus.sram_csb_a) csb_low_cnt++;
      if (busy) busy_seen = 1;
      if (hold_chk && prev_v && !prev_r) begin
        tests_run++;
        if (bus.m_valid_o !== 1'b1 || bus.m_byte_o !== prev_b) begin
          tests_failed++;
          $display("FAIL hold_stable: valid=%b byte=%02h, required valid=1 byte=%02h", bus.m_valid_o, bus.m_byte_o, prev_b);
        end
      end
      if (bus.m_valid_o && bus.m_ready_i) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL byte_extra: got %02h, required no byte", bus.m_byte_o);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.m_byte_o !== mon_exp) begin
            tests_failed++;
            $display("FAIL byte_order: got %02h, required %02h", bus.m_byte_o, mon_exp);
          end
        end
      end
      prev_v = bus.m_valid_o;
      prev_r = bus.m_ready_i;
      prev_b = bus.m_byte_o;
    end
  end

  task automatic clear_stats();
    rd_log.delete();
    exp_q.delete();
    csb_low_cnt = 0;
    done_cnt    = 0;
    done_qsize  = -1;
    busy_seen   = 0;
  endtask

  task automatic push_bytes(input logic [AW-1:0] a, input int n);
    logic [31:0] w;
    w = mem[a];
    for (int b = 0; b < n; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic start_xfer(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk); #1;
    base = b; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(input string name, input int max_cyc, input bit bp, input int restart_at);
    bit seen;
    seen = 0;
    vlog.delete();
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(posedge clk); #1;
      bus.m_ready_i = bp ? (c % 3 == 0) : 1'b1;
      start = (c == restart_at);
      @(negedge clk);
      vlog.push_back(bus.m_valid_o);
      if (done) seen = 1;
    end
    @(posedge clk); #1;
    bus.m_ready_i = 1'b1;
    start = 1'b0;
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s_timeout: done_o not seen in %0d cycles, required a pulse", name, max_cyc);
    end
  endtask

  task automatic wait_byte(input string name, input logic [7:0] v, output bit found);
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (bus.m_valid_o && bus.m_byte_o == v) found = 1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL %s_wait: byte %02h never presented", name, v);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if (bus.sram_csb_a !== 1'b1 || bus.sram_addr_a !== 8'h00 || bus.m_byte_o !== 8'h00 ||
        bus.m_valid_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: csb=%b addr=%02h byte=%02h valid=%b busy=%b done=%b, required 1 00 00 0 0 0",
               bus.sram_csb_a, bus.sram_addr_a, bus.m_byte_o, bus.m_valid_o, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    clear_stats();
    push_bytes(8'h10, 4); push_bytes(8'h11, 4);
    start_xfer(8'h10, 9'd2);
    run_xfer("basic", 100, 1'b0, -1);
    idle(3);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL basic_bytes_left: %0d left, required 0", exp_q.size()); end
    tests_run++;
    if (rd_log.size() != 2 || rd_log[0] !== 8'h10 || rd_log[1] !== 8'h11) begin
      tests_failed++; $display("FAIL basic_reads: %0d reads, required 2 at 10,11", rd_log.size());
    end
    tests_run++;
    if (csb_low_cnt != 2) begin tests_failed++; $display("FAIL basic_csb_cycles: %0d, required 2", csb_low_cnt); end
    tests_run++;
    if (done_cnt != 1 || done_qsize != 0) begin
      tests_failed++; $display("FAIL basic_done: pulses=%0d pending_at_done=%0d, required 1 and 0", done_cnt, done_qsize);
    end
  endtask

  task automatic test_backpressure();
    clear_stats();
    push_bytes(8'h10, 4); push_bytes(8'h11, 4);
    hold_chk = 1;
    start_xfer(8'h10, 9'd2);
    run_xfer("backpressure", 200, 1'b1, -1);
    hold_chk = 0;
    idle(2);
    tests_run++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      tests_failed++; $display("FAIL bp_complete: left=%0d done=%0d, required 0 and 1", exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_wrap();
    clear_stats();
    push_bytes(8'hFF, 4); push_bytes(8'h00, 4);
    start_xfer(8'hFF, 9'd2);
    run_xfer("wrap", 100, 1'b0, -1);
    tests_run++;
    if (rd_log.size() != 2 || rd_log[0] !== 8'hFF || rd_log[1] !== 8'h00 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL wrap_reads: %0d reads left=%0d, required FF,00 and 0", rd_log.size(), exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    clear_stats();
    start_xfer(8'h55, 9'd0);
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL zero_done: done=%b busy=%b, required 1 0", done, busy);
    end
    idle(4);
    tests_run++;
    if (done_cnt != 1 || csb_low_cnt != 0 || busy_seen) begin
      tests_failed++; $display("FAIL zero_quiet: done=%0d csb_low=%0d busy_seen=%0d, required 1 0 0", done_cnt, csb_low_cnt, busy_seen);
    end
  endtask

  task automatic test_abort_restart();
    bit found;
    logic [31:0] w;
    clear_stats();
    w = mem[8'h10];
    push_bytes(8'h10, 3);
    start_xfer(8'h10, 9'd2);
    wait_byte("abort", w[23:16], found);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.m_valid_o !== 1'b0 || busy !== 1'b0 || bus.sram_csb_a !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_state: valid=%b busy=%b csb=%b done=%b, required 0 0 1 0", bus.m_valid_o, busy, bus.sram_csb_a, done);
    end
    idle(4);
    tests_run++;
    if (done_cnt != 0 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL abort_after: done=%0d left=%0d, required 0 0", done_cnt, exp_q.size());
    end
    clear_stats();
    push_bytes(8'h20, 4);
    start_xfer(8'h20, 9'd1);
    run_xfer("restart", 100, 1'b0, -1);
    tests_run++;
    if (rd_log.size() != 1 || rd_log[0] !== 8'h20 || exp_q.size() != 0 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL restart: reads=%0d left=%0d done=%0d, required 1 0 1", rd_log.size(), exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    clear_stats();
    for (int i = 0; i < 4; i++) push_bytes(8'(8'h30 + i), 4);
    start_xfer(8'h30, 9'd4);
    base = 8'h80; len = 9'd1;
    run_xfer("busy_start", 200, 1'b0, 5);
    idle(3);
    ok = (rd_log.size() == 4);
    for (int i = 0; i < 4 && ok; i++) if (rd_log[i] !== 8'(8'h30 + i)) ok = 0;
    tests_run++;
    if (!ok || exp_q.size() != 0 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL busy_start: reads=%0d left=%0d done=%0d, required 4 0 1", rd_log.size(), exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    logic [31:0] w;
    clear_stats();
    w = mem[8'h10];
    push_bytes(8'h10, 2);
    start_xfer(8'h10, 9'd2);
    wait_byte("rst_mid", w[15:8], found);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.sram_csb_a !== 1'b1 || bus.sram_addr_a !== 8'h00 || bus.m_byte_o !== 8'h00 ||
        bus.m_valid_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_values: csb=%b addr=%02h byte=%02h valid=%b busy=%b done=%b, required 1 00 00 0 0 0",
               bus.sram_csb_a, bus.sram_addr_a, bus.m_byte_o, bus.m_valid_o, busy, done);
    end
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rst_mid_bytes: left=%0d, required 0", exp_q.size()); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_gap();
    int first, last, ones, gaps, bad, run;
    clear_stats();
    for (int i = 0; i < 4; i++) push_bytes(8'(8'h40 + i), 4);
    start_xfer(8'h40, 9'd4);
    run_xfer("gap", 200, 1'b0, -1);
    first = -1; last = -1; ones = 0; gaps = 0; bad = 0; run = 0;
    for (int i = 0; i < vlog.size(); i++) if (vlog[i]) begin if (first < 0) first = i; last = i; end
    for (int i = first; i >= 0 && i <= last; i++) begin
      if (vlog[i]) begin
        ones++;
        if (run > 0) begin gaps++; if (run != 1 + RD_LAT) bad++; run = 0; end
      end else run++;
    end
    tests_run++;
    if (ones != 16 || exp_q.size() != 0 || rd_log.size() != 4) begin
      tests_failed++; $display("FAIL gap_bytes: valid=%0d left=%0d reads=%0d, required 16 0 4", ones, exp_q.size(), rd_log.size());
    end
    tests_run++;
`ifdef SRAM_STREAM_PREFETCH_EN
    if (gaps != 0) begin tests_failed++; $display("FAIL gap_prefetch: %0d gaps, required 0", gaps); end
`else
    if (gaps != 3 || bad != 0) begin
      tests_failed++; $display("FAIL gap_seq: %0d gaps %0d wrong length, required 3 of %0d cycles", gaps, bad, 1 + RD_LAT);
    end
`endif
  endtask

  initial begin
    bus.m_ready_i = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'h44332211;
    mem[8'h11] = 32'h88776655;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_abort_restart();
    test_start_while_busy();
    test_reset_mid();
    test_gap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- Read-side consumer of SRAM port A (the port for which the SRAM Wishbone wrapper drives only chip-select and address).
- On a start command, reads a block of 32-bit words from port A. Serializes each word LSB-first into an 8-bit valid/ready byte stream, which feeds the UART TX path.
- Sits between the SRAM macro's port A and the UART transmit stream; control comes from LA or register bits in user_proj_example.

Parameters:
- SRAM_ADDR_WD, 8, SRAM word-address width; addresses wrap modulo 2^SRAM_ADDR_WD.
- SRAM_DATA_WD, 32, SRAM word width; fixed at 32 (4 bytes per word).
- RD_LAT, 1, cycles from the edge where the SRAM samples csb_a=0 to the edge where sram_dout_a is captured; range 1..3.

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle start pulse; ignored while busy_o=1.
- abort_i  in  1  cancel current transfer.
- base_addr_i  in  SRAM_ADDR_WD  first word address, sampled on accepted start.
- len_i  in  SRAM_ADDR_WD+1  word count 0..2^SRAM_ADDR_WD, sampled on accepted start.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle pulse on normal completion.
- sram_csb_a  out  1  port A chip select, active low, registered.
- sram_addr_a  out  SRAM_ADDR_WD  port A address, registered.
- sram_dout_a  in  32  port A read data.
- m_byte_o  out  8  stream byte.
- m_valid_o  out  1  stream valid.
- m_ready_i  in  1  stream ready.

Behaviour:
- Reset values: sram_csb_a=1, sram_addr_a=0, m_byte_o=0, m_valid_o=0, busy_o=0, done_o=0. State=IDLE; word counter=0; byte index=0.
- IDLE:
  - start_i=1 and len_i=0: done_o=1 on the next cycle, busy_o stays 0, no SRAM access.
  - start_i=1 and len_i>0: latch base and len, busy_o=1, go to READ.
- READ: drive sram_csb_a=0 and sram_addr_a=(base+word_idx) mod 2^SRAM_ADDR_WD for exactly one cycle, then csb_a=1; go to WAIT.
- WAIT: count RD_LAT cycles, capture sram_dout_a into the word register, go to SEND.
- SEND:
  - Present byte[idx] (idx 0..3, bits 8*idx+7:8*idx) with m_valid_o=1.
  - A byte transfers when m_valid_o && m_ready_i; on transfer, idx increments.
  - While m_valid_o && !m_ready_i, m_byte_o and m_valid_o hold stable.
  - After byte 3 transfers: if word_idx+1 < len, increment word_idx and go to READ; otherwise go to DONE.
- DONE: done_o=1 for one cycle, busy_o=0, return to IDLE.
- start_i while busy_o=1: ignored, no effect on the current transfer.
- abort_i=1 in any non-IDLE state (priority over start_i and stream handshake):
  - Next cycle: IDLE, sram_csb_a=1, m_valid_o=0, busy_o=0. No done_o.
  - A byte accepted in the same cycle as abort_i counts as transferred.
- Address wrap: base 0xFF with len 2 reads 0xFF then 0x00.
- Reset mid-transfer: all outputs return to reset values on the next edge.
- Without prefetch, inter-word gap on the stream is 1+RD_LAT cycles of m_valid_o=0.

Optional Feature:
- Macro: SRAM_STREAM_PREFETCH_EN.
- Defined:
  - A second 32-bit holding register is added. The next word's READ is issued while the current word serializes, once idx reaches 1; at most one outstanding read.
  - Byte 0 of the next word is valid the cycle after byte 3 transfers (no bubble at m_ready_i=1).
  - Prefetch never reads beyond len words.
  - Abort discards any prefetched data.
- Undefined: sequential behaviour exactly as described above.

Test Plan:
- Basic transfer: SRAM[0x10]=0x44332211, SRAM[0x11]=0x88776655; start, base=0x10, len=2, ready=1.
  - Bytes 11,22,33,44,55,66,77,88 in order; csb_a low exactly twice, at 0x10 then 0x11; done_o pulses once after the last byte.
- Backpressure: same data, m_ready_i toggles 1,0,0,1,...
  - m_byte_o is held stable during every ready=0 cycle; same 8-byte sequence; no byte duplicated or dropped.
- Wrap and zero length:
  - base=0xFF, len=2: addresses 0xFF, 0x00.
  - len=0: done_o on the cycle after start, csb_a never low, busy_o never 1.
- Abort and restart:
  - abort_i during byte 2 of word 0: next cycle m_valid_o=0, busy_o=0, csb_a=1, no done_o.
  - A new start, base=0x20, len=1: streams SRAM[0x20] correctly.
- Start while busy and reset mid-operation:
  - A second start during a len=4 transfer changes nothing.
  - wb_rst_i asserted mid-SEND: all outputs at reset values next cycle.
- Prefetch (with SRAM_STREAM_PREFETCH_EN), len=4, ready=1:
  - m_valid_o is continuously 1 for 16 cycles; exactly 4 SRAM reads.
  - Without the macro: 3 gaps of 1+RD_LAT cycles each.
